// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
//   Parametrised LFSR. The structure (Fibonacci or Galois) is selected at
//   runtime. It supports a synchronous seed load, which substitutes
//   DEFAULT_SEED for an all-zero seed, and a period monitor that measures the
//   length of each completed cycle back to an anchor state.
//
// Parameters
//   WIDTH        state width, 2..32
//   TAPS         feedback tap mask; TAPS[WIDTH-1] must be 1
//   DEFAULT_SEED non-zero seed used at reset and in place of an all-zero load
//
// Ports
//   clk       in   rising-edge clock
//   rset      in   asynchronous active-low reset
//   load      in   synchronous seed load (priority over en)
//   seed      in   seed value captured when load=1
//   en        in   advance one step
//   mode      in   0 = Fibonacci, 1 = Galois
//   out       out  current LFSR state
//   bit_out   out  serial output, out[WIDTH-1]
//   wrap      out  one-cycle pulse when a step returns the state to the anchor
//   period    out  length of the last completed cycle (0 until the first wrap)
//   seed_fix  out  one-cycle pulse when an all-zero seed was replaced
// -----------------------------------------------------------------------------
module lfsr_gen #(
  parameter int unsigned      WIDTH        = 5,
  parameter logic [WIDTH-1:0] TAPS         = 5'b10100,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] out,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             seed_fix
);

  // Galois feedback mask: bit 0 always receives the feedback bit, and bit j
  // receives it when tap j-1 is set.
  localparam logic [WIDTH-1:0] GAL_MASK = {TAPS[WIDTH-2:0], 1'b1};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] q;       // LFSR state
  logic [WIDTH-1:0] anchor;  // reference state for the period monitor
  logic [WIDTH-1:0] cnt;     // steps taken since the anchor
  logic             mode_q;  // mode seen on the previous edge

  logic [WIDTH-1:0] nxt_fib;
  logic [WIDTH-1:0] nxt_gal;
  logic [WIDTH-1:0] nxt_state;
  logic [WIDTH-1:0] post_state;
  logic [WIDTH-1:0] load_val;
  logic             mode_chg;

  // NOTE: every always_comb output gets a value on every path, so no latch is
  // inferred.
  always_comb begin
    nxt_fib    = {q[WIDTH-2:0], ^(q & TAPS)};
    nxt_gal    = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? GAL_MASK : '0);
    // The step function follows the live mode input, not mode_q.
    nxt_state  = mode ? nxt_gal : nxt_fib;
    post_state = en ? nxt_state : q;
    load_val   = (seed == '0) ? DEFAULT_SEED : seed;
    mode_chg   = (mode != mode_q);
  end

  // NOTE: all state is updated with non-blocking assignments, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rset) begin
    if (!rset) begin
      q        <= DEFAULT_SEED;
      anchor   <= DEFAULT_SEED;
      cnt      <= '0;
      period   <= '0;
      mode_q   <= 1'b0;
      wrap     <= 1'b0;
      seed_fix <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      seed_fix <= 1'b0;
      if (load) begin
        // A load discards any step requested on the same edge.
        q        <= load_val;
        anchor   <= load_val;
        cnt      <= '0;
        seed_fix <= (seed == '0);
        mode_q   <= mode;
      end else if (mode_chg) begin
        // A structure switch starts a new sequence, so re-anchor on the state
        // that q holds after this edge. The period measurement restarts.
        mode_q <= mode;
        anchor <= post_state;
        cnt    <= '0;
        q      <= post_state;
      end else if (en) begin
        q <= nxt_state;
        if (nxt_state == anchor) begin
          wrap   <= 1'b1;
          period <= cnt + ONE;
          cnt    <= '0;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

  assign out     = q;
  assign bit_out = q[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
//   Self-checking bench for lfsr_gen (WIDTH=5, TAPS=10100, DEFAULT_SEED=1).
//   It runs a table of directed vectors, then hand-written multi-cycle
//   sequences, then randomized stimulus compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

  localparam int W     = 5;
  localparam int TAPS  = 20;  // 5'b10100
  localparam int DSEED = 1;
  localparam int NST   = 32;  // 2**W

  logic         clk;
  logic         rset;
  logic         load;
  logic [W-1:0] seed;
  logic         en;
  logic         mode;
  logic [W-1:0] out;
  logic         bit_out;
  logic         wrap;
  logic [W-1:0] period;
  logic         seed_fix;

  lfsr_gen #(
    .WIDTH       (W),
    .TAPS        (5'b10100),
    .DEFAULT_SEED(5'd1)
  ) dut (
    .clk     (clk),
    .rset    (rset),
    .load    (load),
    .seed    (seed),
    .en      (en),
    .mode    (mode),
    .out     (out),
    .bit_out (bit_out),
    .wrap    (wrap),
    .period  (period),
    .seed_fix(seed_fix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: integer state, arithmetic step rules, and a queue of
  // the states visited since the anchor. The period is the length of that
  // queue when the anchor is revisited.
  // ---------------------------------------------------------------------------
  int unsigned m_q, m_anchor, m_period;
  bit          m_mode, m_wrap, m_fix;
  int unsigned hist[$];

  function automatic int unsigned ref_next(int unsigned s, bit md);
    int unsigned fb;
    int unsigned gmask;
    if (!md) begin
      fb = 0;
      for (int i = 0; i < W; i++)
        if (((TAPS >> i) & 1) != 0) fb ^= (s >> i) & 1;
      return ((s * 2) % NST) + fb;
    end
    gmask = ((TAPS * 2) % NST) | 1;
    return ((s * 2) % NST) ^ ((s >= NST / 2) ? gmask : 0);
  endfunction

  task automatic model_reset();
    m_q = DSEED; m_anchor = DSEED; m_period = 0;
    m_mode = 0; m_wrap = 0; m_fix = 0;
    hist.delete();
  endtask

  task automatic model_apply(input bit ld, input bit e, input bit md,
                             input int unsigned sd);
    m_wrap = 0;
    m_fix  = 0;
    if (ld) begin
      m_fix    = (sd == 0);
      m_q      = (sd == 0) ? DSEED : sd;
      m_anchor = m_q;
      m_mode   = md;
      hist.delete();
    end else if (md != m_mode) begin
      m_mode = md;
      if (e) m_q = ref_next(m_q, md);
      m_anchor = m_q;
      hist.delete();
    end else if (e) begin
      m_q = ref_next(m_q, md);
      hist.push_back(m_q);
      if (m_q == m_anchor) begin
        m_wrap   = 1;
        m_period = hist.size();
        hist.delete();
      end
    end
  endtask

  // One clock: drive the inputs, let the edge happen, sample 1 ns later.
  task automatic cycle(input bit ld, input bit e, input bit md,
                       input logic [W-1:0] sd);
    load = ld; en = e; mode = md; seed = sd;
    model_apply(ld, e, md, sd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},      out,      m_q);
    check({tag, ".bit_out"},  bit_out,  (m_q >> (W - 1)) & 1);
    check({tag, ".wrap"},     wrap,     m_wrap);
    check({tag, ".seed_fix"}, seed_fix, m_fix);
    check({tag, ".period"},   period,   m_period);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         ld;
    logic         e;
    logic         md;
    logic [W-1:0] sd;
    logic [W-1:0] e_out;
    logic         e_wrap;
    logic         e_fix;
    logic [W-1:0] e_per;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bit seen [NST];
    int wraps;

    // {ld, en, mode, seed, out, wrap, seed_fix, period}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'b00111, 5'b00111, 1'b0, 1'b0, 5'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b01111, 1'b0, 1'b0, 5'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b0, 5'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b11110, 1'b0, 1'b0, 5'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b11100, 1'b0, 1'b0, 5'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 5'b00111, 5'b00111, 1'b0, 1'b0, 5'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 5'b00000, 5'b01110, 1'b0, 1'b0, 5'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 5'b00000, 5'b11100, 1'b0, 1'b0, 5'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 5'b00000, 5'b10001, 1'b0, 1'b0, 5'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 5'b00000, 5'b01011, 1'b0, 1'b0, 5'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 5'b00000, 5'b00001, 1'b0, 1'b1, 5'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00001, 1'b0, 1'b0, 5'd0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 5'b10101, 5'b10101, 1'b0, 1'b0, 5'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b10101, 1'b0, 1'b0, 5'd0};

    // ---- reset ----
    rset = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0; seed = '0;
    model_reset();
    #12;
    check("reset.out",      out,      5'd1);
    check("reset.period",   period,   5'd0);
    check("reset.wrap",     wrap,     1'b0);
    check("reset.seed_fix", seed_fix, 1'b0);
    check("reset.bit_out",  bit_out,  1'b0);
    @(negedge clk);
    rset = 1'b1;

    // ---- table ----
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].ld, tbl[i].e, tbl[i].md, tbl[i].sd);
      check($sformatf("tbl%0d.out", i),      out,      tbl[i].e_out);
      check($sformatf("tbl%0d.wrap", i),     wrap,     tbl[i].e_wrap);
      check($sformatf("tbl%0d.seed_fix", i), seed_fix, tbl[i].e_fix);
      check($sformatf("tbl%0d.period", i),   period,   tbl[i].e_per);
    end
    // The load+en row must also have cleared cnt: 31 steps from 10101 wrap.
    for (int i = 0; i < 31; i++) begin
      cycle(1'b0, 1'b1, 1'b1, '0);
      check("ldEn.wrap", wrap, (i == 30));
    end
    check("ldEn.period", period, 5'd31);

    // ---- full Fibonacci cycle from 00111 ----
    cycle(1'b1, 1'b0, 1'b0, 5'b00111);
    check_model("fib_ld");
    for (int i = 0; i < NST; i++) seen[i] = 1'b0;
    seen[7] = 1'b1;
    for (int i = 0; i < 31; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      check_model("fib31");
      check("fib31.wrap_edge", wrap, (i == 30));
      if (i < 30) begin
        check("fib31.nonzero", (out != 0), 1'b1);
        check("fib31.distinct", seen[out], 1'b0);
        seen[out] = 1'b1;
      end
    end
    check("fib31.final_out", out,    5'b00111);
    check("fib31.period",    period, 5'd31);

    // ---- zero seed replacement, then a full cycle ----
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    check("zero.out",      out,      5'b00001);
    check("zero.seed_fix", seed_fix, 1'b1);
    check("zero.period_kept", period, 5'd31);
    wraps = 0;
    for (int i = 0; i < 31; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      check("zero.fix_pulse", seed_fix, 1'b0);
      wraps += int'(wrap);
      check_model("zero31");
    end
    check("zero.wraps",  wraps,  1);
    check("zero.wrap",   wrap,   1'b1);
    check("zero.period", period, 5'd31);

    // ---- mode flip after 10 Fibonacci steps, then 31 Galois steps ----
    cycle(1'b1, 1'b0, 1'b0, 5'b00111);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    check_model("flip_pre");
    cycle(1'b0, 1'b1, 1'b1, '0);
    check("flip.wrap", wrap, 1'b0);
    check_model("flip");
    for (int i = 0; i < 31; i++) begin
      cycle(1'b0, 1'b1, 1'b1, '0);
      check("gal31.wrap_edge", wrap, (i == 30));
      check_model("gal31");
    end
    check("gal31.period", period, 5'd31);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, '0);

    // ---- asynchronous reset mid-run ----
    #2 rset = 1'b0;
    #1;
    model_reset();
    check("midrst.out",    out,    5'b00001);
    check("midrst.period", period, 5'd0);
    check("midrst.wrap",   wrap,   1'b0);
    @(negedge clk);
    rset = 1'b1;

    // ---- randomized stimulus against the model ----
    for (int i = 0; i < 1500; i++) begin
      bit          r_ld, r_en, r_md;
      int unsigned r_sd;
      if ($urandom_range(0, 199) == 0) begin
        #2 rset = 1'b0;
        #1;
        model_reset();
        check_model("rnd_rst");
        @(negedge clk);
        rset = 1'b1;
      end
      r_ld = ($urandom_range(0, 39) == 0);
      r_en = ($urandom_range(0, 9) < 8);
      r_md = ($urandom_range(0, 59) == 0) ? ~m_mode : m_mode;
      r_sd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, NST - 1);
      cycle(r_ld, r_en, r_md, W'(r_sd));
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
